// File: rtl/plot_op_scheduler.sv
// plot_op_scheduler: grants the shared pixel-plot path to one of five requesters and times its op line.
// Optional SCHED_RR_EN: round-robin among draw/heap/erase instead of fixed order 2,0,1.
`default_nettype none

module plot_op_scheduler #(
    parameter int CUBE_CYCLES  = 16,
    parameter int ROW_CYCLES   = 160,
    parameter int CLEAR_CYCLES = 16384,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  req,
    input  logic [34:0] req_x,
    input  logic [34:0] req_y,
    input  logic [14:0] req_colour,
    output logic [4:0]  grant,
    output logic [4:0]  done,
    output logic [6:0]  out_x,
    output logic [6:0]  out_y,
    output logic [2:0]  out_colour,
    output logic        draw,
    output logic        heap,
    output logic        erase,
    output logic        erase_complete,
    output logic        draw_all_black,
    output logic        busy
);

    localparam int MAX_A   = (CUBE_CYCLES > ROW_CYCLES) ? CUBE_CYCLES : ROW_CYCLES;
    localparam int MAX_DUR = (MAX_A > CLEAR_CYCLES) ? MAX_A : CLEAR_CYCLES;
    localparam int CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]    lines, lines_n, grant_n, done_n;
    logic [6:0]    x_n, y_n, sel_x, sel_y;
    logic [2:0]    colour_n, sel_colour;
    logic          busy_n;
    logic [4:0]    win;
    logic [2:0]    low_win;
    logic [CW-1:0] dur_sel;
    logic          accept;

    assign accept = (state == S_IDLE) && (req != 5'd0);

`ifdef SCHED_RR_EN
    logic [1:0] last;

    // Scan from last+1 modulo 3; iterating downwards leaves the first hit in low_win.
    always_comb begin
        low_win = 3'b000;
        for (int k = 3; k >= 1; k--) begin
            int t;
            t = (int'(last) + k) % 3;
            if (req[t]) low_win = 3'b001 << t;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last <= 2'd2;
        end else if (accept && (win[2:0] != 3'b000)) begin
            last <= win[0] ? 2'd0 : (win[1] ? 2'd1 : 2'd2);
        end
    end
`else
    // Erase ahead of draw so a moving cube clears its old position first.
    always_comb begin
        low_win = 3'b000;
        if (req[2])      low_win = 3'b100;
        else if (req[0]) low_win = 3'b001;
        else if (req[1]) low_win = 3'b010;
    end
`endif

    always_comb begin
        win = 5'd0;
        if (req[4])      win = 5'b10000;
        else if (req[3]) win = 5'b01000;
        else             win = {2'b00, low_win};
    end

    always_comb begin
        sel_x      = 7'd0;
        sel_y      = 7'd0;
        sel_colour = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (win[i]) begin
                sel_x      = req_x[7*i +: 7];
                sel_y      = req_y[7*i +: 7];
                sel_colour = req_colour[3*i +: 3];
            end
        end
        if (win[4])      dur_sel = CW'(CLEAR_CYCLES - 1);
        else if (win[3]) dur_sel = CW'(ROW_CYCLES - 1);
        else             dur_sel = CW'(CUBE_CYCLES - 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lines      <= 5'd0;
            grant      <= 5'd0;
            done       <= 5'd0;
            out_x      <= 7'd0;
            out_y      <= 7'd0;
            out_colour <= 3'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            lines      <= lines_n;
            grant      <= grant_n;
            done       <= done_n;
            out_x      <= x_n;
            out_y      <= y_n;
            out_colour <= colour_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_RUN;
                    cnt_n   = dur_sel;
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_n = S_GAP;
                    cnt_n   = CW'(GAP_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) state_n = S_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the op line register doubles as the winner record.
    always_comb begin
        grant_n  = accept ? win : 5'd0;
        done_n   = ((state == S_RUN) && (cnt == '0)) ? lines : 5'd0;
        lines_n  = 5'd0;
        if (accept)                             lines_n = win;
        else if ((state == S_RUN) && (cnt != '0)) lines_n = lines;
        x_n      = accept ? sel_x : out_x;
        y_n      = accept ? sel_y : out_y;
        colour_n = accept ? sel_colour : out_colour;
        busy_n   = (state_n != S_IDLE);
    end

    assign draw           = lines[0];
    assign heap           = lines[1];
    assign erase          = lines[2];
    assign erase_complete = lines[3];
    assign draw_all_black = lines[4];

endmodule

`default_nettype wire

// File: tb/tb_plot_op_scheduler.sv
// tb_plot_op_scheduler: randomized and directed stimulus checked against a transaction-level model.
`default_nettype none

module tb_plot_op_scheduler;

    localparam int CUBE = 16, ROW = 160, CLEAR = 16384, GAP = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  req = 5'd0;
    logic [34:0] req_x = 35'd0, req_y = 35'd0;
    logic [14:0] req_colour = 15'd0;
    logic [4:0]  grant, done;
    logic [6:0]  out_x, out_y;
    logic [2:0]  out_colour;
    logic        draw, heap, erase, erase_complete, draw_all_black, busy;
    logic [4:0]  ops;

    int checks   = 0;
    int failures = 0;
    int model_last = 2;

    assign ops = {draw_all_black, erase_complete, erase, heap, draw};

    plot_op_scheduler #(
        .CUBE_CYCLES(CUBE), .ROW_CYCLES(ROW), .CLEAR_CYCLES(CLEAR), .GAP_CYCLES(GAP)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .grant(grant), .done(done), .out_x(out_x), .out_y(out_y),
        .out_colour(out_colour), .draw(draw), .heap(heap), .erase(erase),
        .erase_complete(erase_complete), .draw_all_black(draw_all_black), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int dur_of(input int w);
        if (w == 4) return CLEAR;
        if (w == 3) return ROW;
        return CUBE;
    endfunction

    function automatic int pick(input logic [4:0] r);
        if (r[4]) return 4;
        if (r[3]) return 3;
`ifdef SCHED_RR_EN
        for (int k = 1; k <= 3; k++) begin
            if (r[(model_last + k) % 3]) return (model_last + k) % 3;
        end
`else
        if (r[2]) return 2;
        if (r[0]) return 0;
        if (r[1]) return 1;
`endif
        return -1;
    endfunction

    // One full transaction from an IDLE cycle: grant, RUN, GAP, back to IDLE.
    task automatic do_op(input logic [4:0] r, input bit hold, input bit rnd, input bit mutate,
                         input logic [4:0] late_req, output int wo);
        int w, len, gap, bad;
        logic [6:0] ex, ey;
        logic [2:0] ec;
        req = r;
        if (rnd) begin
            req_x      = 35'({$urandom(), $urandom()});
            req_y      = 35'({$urandom(), $urandom()});
            req_colour = 15'($urandom());
        end
        w  = pick(r);
        wo = w;
        ex = req_x[7*w +: 7];
        ey = req_y[7*w +: 7];
        ec = req_colour[3*w +: 3];
        tick();
        check("grant", grant, 32'(1) << w);
        check("grant_line", ops, 32'(1) << w);
        check("grant_xyc", {out_x, out_y, out_colour}, {ex, ey, ec});
        check("grant_busy", busy, 1);
        if (w <= 2) model_last = w;
        if (!hold) req[w] = 1'b0;
        if (mutate) req_x[7*w +: 7] = (ex == 7'd99) ? 7'd100 : 7'd99;
        len = 1;
        bad = 0;
        tick();
        while (ops != 5'd0 && len < dur_of(w) + 4) begin
            if (ops !== 5'(32'(1) << w) || grant != 5'd0 || done != 5'd0 || !busy) bad++;
            if ({out_x, out_y, out_colour} !== {ex, ey, ec}) bad++;
            if (len == 100 && late_req != 5'd0) req = late_req;
            len++;
            tick();
        end
        check("run_len", len, dur_of(w));
        check("run_excl", bad, 0);
        check("done", done, 32'(1) << w);
        gap = 0;
        bad = 0;
        while (busy && gap < GAP + 4) begin
            if (gap > 0 && done != 5'd0) bad++;
            if (ops != 5'd0 || grant != 5'd0) bad++;
            if ({out_x, out_y, out_colour} !== {ex, ey, ec}) bad++;
            gap++;
            tick();
        end
        check("gap_len", gap, GAP);
        check("gap_quiet", bad, 0);
        check("idle_quiet", {grant, done, ops}, 0);
        check("idle_hold", {out_x, out_y, out_colour}, {ex, ey, ec});
    endtask

    initial begin
        int w;
        int seq[4];
        tick();
        tick();
        check("reset_outs", {grant, done, ops, busy, out_x, out_y, out_colour}, 0);
        reset = 1'b0;
        tick();
        check("idle_no_req", {grant, ops, busy}, 0);

        // Continuous 0/1/2 requests: rotation with round-robin, starvation without.
        for (int i = 0; i < 4; i++) begin
            do_op(5'b00111, 1'b1, 1'b1, 1'b0, 5'd0, w);
            seq[i] = w;
        end
        req = 5'd0;
`ifdef SCHED_RR_EN
        check("rr_seq", {8'(seq[0]), 8'(seq[1]), 8'(seq[2]), 8'(seq[3])}, {8'd0, 8'd1, 8'd2, 8'd0});
`else
        check("fixed_seq", {8'(seq[0]), 8'(seq[1]), 8'(seq[2]), 8'(seq[3])}, {8'd2, 8'd2, 8'd2, 8'd2});
`endif

        // Single draw with known coordinates.
        req_x = 35'd0; req_y = 35'd0; req_colour = 15'd0;
        req_x[6:0] = 7'd10; req_y[6:0] = 7'd20; req_colour[2:0] = 3'd3;
        do_op(5'b00001, 1'b0, 1'b0, 1'b0, 5'd0, w);
        check("single_xyc", {out_x, out_y, out_colour}, {7'd10, 7'd20, 3'd3});

        // Simultaneous requests; each requester drops its own bit after grant.
        for (int i = 0; i < 3; i++) begin
            do_op((i == 0) ? 5'b00111 : req, 1'b0, 1'b1, 1'b0, 5'd0, w);
            seq[i] = w;
        end
        req = 5'd0;
`ifndef SCHED_RR_EN
        check("simul_seq", {8'(seq[0]), 8'(seq[1]), 8'(seq[2])}, {8'd2, 8'd0, 8'd1});
`endif

        // Coordinates change after grant must not reach the outputs.
        do_op(5'b00100, 1'b0, 1'b1, 1'b1, 5'd0, w);

        for (int i = 0; i < 10; i++) begin
            do_op(5'($urandom_range(1, 15)), 1'b0, 1'b1, ($urandom_range(0, 1) == 1), 5'd0, w);
            req = 5'd0;
        end

        // Full clear; draw raised mid-RUN waits for IDLE.
        do_op(5'b10000, 1'b0, 1'b1, 1'b0, 5'b00001, w);
        do_op(req, 1'b0, 1'b1, 1'b0, 5'd0, w);
        check("late_draw", w, 0);

        // Reset at cycle 7 of an erase_complete RUN.
        req = 5'b01000;
        tick();
        check("rst_grant", grant, 5'b01000);
        for (int i = 0; i < 6; i++) tick();
        check("rst_pre_line", ops, 5'b01000);
        reset = 1'b1;
        tick();
        check("rst_outs", {grant, done, ops, busy, out_x, out_y, out_colour}, 0);
        tick();
        check("rst_hold", {grant, done, ops, busy}, 0);
        reset = 1'b0;
        model_last = 2;
        do_op(5'b01000, 1'b0, 1'b1, 1'b0, 5'd0, w);
        req = 5'd0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
